// File: rtl/register_file_mp.sv
// Multi-ported register file with a write-clears/issue-sets scoreboard.
// After reset, a CLEAR sequence zeroes one register per cycle before rdy rises.
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  localparam int SEL_W = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NWR-1:0]        WEN,
  input  logic [NWR*SEL_W-1:0]  wsel,
  input  logic [NWR*DATA_W-1:0] wdat,
  input  logic [NRD*SEL_W-1:0]  rsel,
  output logic [NRD*DATA_W-1:0] rdat,
  input  logic                  issue_en,
  input  logic [SEL_W-1:0]      issue_sel,
  output logic [NRD-1:0]        rbusy,
  output logic [NREGS-1:0]      busy,
  output logic                  rdy
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NREGS - 1);

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    cnt, cnt_nxt;
  logic [NREGS-1:0]    busy_nxt;
  logic [DATA_W-1:0]   regs [NREGS];

  logic [SEL_W-1:0]    wsel_a [NWR];
  logic [DATA_W-1:0]   wdat_a [NWR];
  logic [SEL_W-1:0]    rsel_a [NRD];
  logic [DATA_W-1:0]   rd_val [NRD];
  logic                hit    [NRD];

  for (genvar i = 0; i < NWR; i++) begin : g_wr
    assign wsel_a[i] = wsel[i*SEL_W +: SEL_W];
    assign wdat_a[i] = wdat[i*DATA_W +: DATA_W];
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    assign rsel_a[j] = rsel[j*SEL_W +: SEL_W];
    assign rdat[j*DATA_W +: DATA_W] = rd_val[j];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + SEL_W'(1);
        if (cnt == LAST) state_nxt = READY;
      end
      READY: state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Writes clear pending bits first so a same-cycle issue keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (state == READY) begin
      for (int i = 0; i < NWR; i++) begin
        if (WEN[i] && wsel_a[i] != '0) busy_nxt[wsel_a[i]] = 1'b0;
      end
      if (issue_en && issue_sel != '0) busy_nxt[issue_sel] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
    end
  end

  // Ascending port order makes the highest-index port win on a collision.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        regs[cnt] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          if (WEN[i] && wsel_a[i] != '0) regs[wsel_a[i]] <= wdat_a[i];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd_val[j] = regs[rsel_a[j]];
      hit[j]    = 1'b0;
      rbusy[j]  = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        if (WEN[i] && wsel_a[i] == rsel_a[j]) begin
          rd_val[j] = wdat_a[i];
          hit[j]    = 1'b1;
        end
      end
      if (state != READY || rsel_a[j] == '0) begin
        rd_val[j] = '0;
      end else begin
        rbusy[j] = busy[rsel_a[j]] && !hit[j];
      end
    end
  end

  assign rdy = (state == READY);

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: clear sequence, bypass, port priority,
// scoreboard set/clear and mid-clear reset restart.
module tb_register_file_mp;

  logic        CLK;
  logic        RST;
  logic [1:0]  WEN;
  logic [9:0]  wsel;
  logic [63:0] wdat;
  logic [9:0]  rsel;
  logic [63:0] rdat;
  logic        issue_en;
  logic [4:0]  issue_sel;
  logic [1:0]  rbusy;
  logic [31:0] busy;
  logic        rdy;

  int checks = 0;
  int errors = 0;

  register_file_mp #(.DATA_W(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat), .issue_en(issue_en), .issue_sel(issue_sel),
    .rbusy(rbusy), .busy(busy), .rdy(rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  ws0, ws1;
    logic [31:0] wd0, wd1;
    logic [4:0]  rs0, rs1;
    logic        ie;
    logic [4:0]  isel;
    logic [31:0] e0, e1;
    logic [1:0]  erb;
    logic [31:0] ebusy;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic [1:0] wen, logic [4:0] ws0, logic [31:0] wd0,
                              logic [4:0] ws1, logic [31:0] wd1,
                              logic [4:0] rs0, logic [4:0] rs1,
                              logic ie, logic [4:0] isel,
                              logic [31:0] e0, logic [31:0] e1,
                              logic [1:0] erb, logic [31:0] ebusy);
    vec_t v;
    v.wen = wen; v.ws0 = ws0; v.wd0 = wd0; v.ws1 = ws1; v.wd1 = wd1;
    v.rs0 = rs0; v.rs1 = rs1; v.ie = ie; v.isel = isel;
    v.e0 = e0; v.e1 = e1; v.erb = erb; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WEN = '0; wsel = '0; wdat = '0; issue_en = 1'b0; issue_sel = '0;
  endtask

  localparam logic [31:0] B9  = 32'h1 << 9;
  localparam logic [31:0] B12 = 32'h1 << 12;

  initial begin
    tbl[0]  = mk(2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0);
    tbl[1]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0);
    tbl[2]  = mk(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 5'd3, 1'b0, 5'd0, 32'h22, 32'hDEADBEEF, 2'b00, 32'h0);
    tbl[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0, 32'h22, 32'h22, 2'b00, 32'h0);
    tbl[4]  = mk(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 32'h22, 2'b00, 32'h0);
    tbl[5]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0);
    tbl[6]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 32'h0, 32'h0, 2'b00, 32'h0);
    tbl[7]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b01, B9);
    tbl[8]  = mk(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 5'd9, 5'd9, 1'b0, 5'd0, 32'h99, 32'h99, 2'b00, B9);
    tbl[9]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 32'h99, 32'h0, 2'b00, 32'h0);
    tbl[10] = mk(2'b01, 5'd9, 32'hAA, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 32'hAA, 32'h0, 2'b00, 32'h0);
    tbl[11] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 32'hAA, 32'hAA, 2'b11, B9);
    tbl[12] = mk(2'b11, 5'd12, 32'h1200, 5'd13, 32'h1300, 5'd13, 5'd12, 1'b0, 5'd0, 32'h1300, 32'h1200, 2'b00, B9);
    tbl[13] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd12, 5'd13, 1'b1, 5'd12, 32'h1200, 32'h1300, 2'b00, B9);
    tbl[14] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd12, 5'd9, 1'b0, 5'd0, 32'h1200, 32'hAA, 2'b11, B9 | B12);
    tbl[15] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0, 2'b00, B9 | B12);
    tbl[16] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, B9 | B12);

    idle();
    rsel = {5'd4, 5'd5};
    RST  = 1'b1;
    tick();
    RST  = 1'b0;

    // Clear phase: 32 cycles with rdy low; a write/issue to reg 4 at cycle 10 is ignored.
    for (int c = 1; c <= 32; c++) begin
      if (c == 10) begin
        WEN = 2'b01; wsel = {5'd0, 5'd4}; wdat = {32'h0, 32'h55};
        issue_en = 1'b1; issue_sel = 5'd4;
      end
      #1;
      chk($sformatf("clear_rdy_c%0d", c), {63'd0, rdy}, 64'd0);
      chk($sformatf("clear_rdat_c%0d", c), rdat, 64'd0);
      chk($sformatf("clear_rbusy_c%0d", c), {62'd0, rbusy}, 64'd0);
      tick();
      idle();
    end
    #1;
    chk("rdy_after_clear", {63'd0, rdy}, 64'd1);
    chk("reg4_after_clear", rdat[63:32], 64'd0);
    chk("reg5_after_clear", rdat[31:0], 64'd0);
    chk("busy_after_clear", {32'd0, busy}, 64'd0);

    for (int k = 0; k < 17; k++) begin
      WEN = tbl[k].wen;
      wsel = {tbl[k].ws1, tbl[k].ws0};
      wdat = {tbl[k].wd1, tbl[k].wd0};
      rsel = {tbl[k].rs1, tbl[k].rs0};
      issue_en = tbl[k].ie;
      issue_sel = tbl[k].isel;
      #1;
      chk($sformatf("v%0d_rdat0", k), {32'd0, rdat[31:0]}, {32'd0, tbl[k].e0});
      chk($sformatf("v%0d_rdat1", k), {32'd0, rdat[63:32]}, {32'd0, tbl[k].e1});
      chk($sformatf("v%0d_rbusy", k), {62'd0, rbusy}, {62'd0, tbl[k].erb});
      chk($sformatf("v%0d_busy", k), {32'd0, busy}, {32'd0, tbl[k].ebusy});
      tick();
    end
    idle();

    // Reset mid-clear at cycle 20 restarts the full 32-cycle sequence.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("busy_after_reset", {32'd0, busy}, 64'd0);
    for (int c = 1; c < 20; c++) tick();
    RST = 1'b1;
    #1;
    chk("rdy_before_pulse", {63'd0, rdy}, 64'd0);
    tick();
    RST = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      #1;
      chk($sformatf("restart_rdy_c%0d", c), {63'd0, rdy}, 64'd0);
      tick();
    end
    rsel = {5'd7, 5'd3};
    #1;
    chk("rdy_after_restart", {63'd0, rdy}, 64'd1);
    chk("reg3_zeroed", {32'd0, rdat[31:0]}, 64'd0);
    chk("reg7_zeroed", {32'd0, rdat[63:32]}, 64'd0);
    chk("busy_zeroed", {32'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
